// File: rtl/i2c_m_axil_slave_pkg.sv
// Shared definitions for the I2C master AXI4-Lite register block:
// register offsets, CTRL bit positions, response codes and FSM state types.
package i2c_m_axil_pkg;

  localparam logic [4:0] OFF_CTRL    = 5'h00;
  localparam logic [4:0] OFF_TXD     = 5'h04;
  localparam logic [4:0] OFF_SADDR   = 5'h08;
  localparam logic [4:0] OFF_SCRATCH = 5'h0C;
  localparam logic [4:0] OFF_STATUS  = 5'h10;
  localparam logic [4:0] OFF_RXD     = 5'h14;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_START    = 1;
  localparam int CTRL_DONE_CLR = 2;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_t;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_RESP} rd_state_t;

  function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/i2c_m_axil_slave_if.sv
// AXI4-Lite channel bundle between the register-block responder and its initiator.
interface i2c_m_axil_slave_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/i2c_m_axil_slave.sv
// AXI4-Lite responder holding the I2C master control/status registers.
// Define I2C_M_AXIL_SLVERR_EN to answer RO/unmapped writes and unmapped reads with SLVERR.
module i2c_m_axil_slave
  import i2c_m_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic       ACLK,
  input  logic       ARESETN,
  i2c_m_axil_slave_if.slave s_axi,
  output logic       i2c_en,
  output logic       i2c_start,
  output logic [7:0] i2c_tx_data,
  output logic [6:0] i2c_slv_addr,
  output logic       i2c_rw,
  input  logic       i2c_busy,
  input  logic       i2c_done,
  input  logic       i2c_ack_err,
  input  logic [7:0] i2c_rx_data
);

`ifdef I2C_M_AXIL_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  localparam int WORD_MSB = C_S_AXI_ADDR_WIDTH - 1;
  localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [2:0] A_CTRL    = OFF_CTRL[4:2];
  localparam logic [2:0] A_TXD     = OFF_TXD[4:2];
  localparam logic [2:0] A_SADDR   = OFF_SADDR[4:2];
  localparam logic [2:0] A_SCRATCH = OFF_SCRATCH[4:2];
  localparam logic [2:0] A_STATUS  = OFF_STATUS[4:2];
  localparam logic [2:0] A_RXD     = OFF_RXD[4:2];

  // START and DONE_CLR are action bits: never stored, always read back as 0
  localparam logic [31:0] CTRL_KEEP = ~((32'h1 << CTRL_START) | (32'h1 << CTRL_DONE_CLR));

  wr_state_t wst, wst_nxt;
  rd_state_t rst_q, rst_nxt;

  logic [2:0]                    aw_word_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]             wstrb_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic [2:0]  c_word;
  logic [31:0] c_data;
  logic [3:0]  c_strb;
  logic        c_rw, c_ctrl, done_clr;

  logic [31:0] ctrl_q, txd_q, saddr_q, scratch_q;
  logic        done_st, ack_st, start_q;
  axi_resp_t   bresp_q, rresp_q, rd_resp;
  logic [31:0] rdata_q, rd_val;

  assign s_axi.awready = (wst == W_IDLE) || (wst == W_HAVE_D);
  assign s_axi.wready  = (wst == W_IDLE) || (wst == W_HAVE_A);
  assign s_axi.bvalid  = (wst == W_RESP);
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = (rst_q == R_IDLE);
  assign s_axi.rvalid  = (rst_q == R_RESP);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  assign aw_hs = s_axi.awvalid & s_axi.awready;
  assign w_hs  = s_axi.wvalid  & s_axi.wready;
  assign b_hs  = s_axi.bvalid  & s_axi.bready;
  assign ar_hs = s_axi.arvalid & s_axi.arready;
  assign r_hs  = s_axi.rvalid  & s_axi.rready;

  // Commit uses whichever half arrived earlier from its holding register, the other live
  assign c_word   = (wst == W_HAVE_A) ? aw_word_q : s_axi.awaddr[WORD_MSB:2];
  assign c_data   = (wst == W_HAVE_D) ? wdata_q   : s_axi.wdata;
  assign c_strb   = (wst == W_HAVE_D) ? wstrb_q   : s_axi.wstrb;
  assign c_rw     = (c_word == A_CTRL) || (c_word == A_TXD) ||
                    (c_word == A_SADDR) || (c_word == A_SCRATCH);
  assign c_ctrl   = commit && (c_word == A_CTRL) && c_strb[0];
  assign done_clr = c_ctrl && c_data[CTRL_DONE_CLR];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) wst <= W_IDLE;
    else          wst <= wst_nxt;
  end

  always_comb begin
    wst_nxt = wst;
    commit  = 1'b0;
    case (wst)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit  = 1'b1;
          wst_nxt = W_RESP;
        end else if (aw_hs) wst_nxt = W_HAVE_A;
        else if (w_hs)      wst_nxt = W_HAVE_D;
      end
      W_HAVE_A: if (w_hs)  begin commit = 1'b1; wst_nxt = W_RESP; end
      W_HAVE_D: if (aw_hs) begin commit = 1'b1; wst_nxt = W_RESP; end
      W_RESP:   if (b_hs)  wst_nxt = W_IDLE;
      default:  wst_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_word_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (aw_hs) aw_word_q <= s_axi.awaddr[WORD_MSB:2];
      if (w_hs) begin
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
      end
      if (commit) bresp_q <= (SLVERR_EN && !c_rw) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ctrl_q    <= '0;
      txd_q     <= '0;
      saddr_q   <= '0;
      scratch_q <= '0;
      done_st   <= 1'b0;
      ack_st    <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      start_q <= c_ctrl && c_data[CTRL_START];
      // a status pulse in the clearing cycle wins over the clear
      done_st <= i2c_done    | (done_st & ~done_clr);
      ack_st  <= i2c_ack_err | (ack_st  & ~done_clr);
      if (commit) begin
        case (c_word)
          A_CTRL:    ctrl_q    <= apply_strb(ctrl_q, c_data, c_strb) & CTRL_KEEP;
          A_TXD:     txd_q     <= apply_strb(txd_q, c_data, c_strb);
          A_SADDR:   saddr_q   <= apply_strb(saddr_q, c_data, c_strb);
          A_SCRATCH: scratch_q <= apply_strb(scratch_q, c_data, c_strb);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_val  = '0;
    rd_resp = RESP_OKAY;
    case (s_axi.araddr[WORD_MSB:2])
      A_CTRL:    rd_val = ctrl_q;
      A_TXD:     rd_val = txd_q;
      A_SADDR:   rd_val = saddr_q;
      A_SCRATCH: rd_val = scratch_q;
      A_STATUS:  rd_val = {29'b0, ack_st, done_st, i2c_busy};
      A_RXD:     rd_val = {24'b0, i2c_rx_data};
      default:   rd_resp = SLVERR_EN ? RESP_SLVERR : RESP_OKAY;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rst_q <= R_IDLE;
    else          rst_q <= rst_nxt;
  end

  always_comb begin
    rst_nxt = rst_q;
    case (rst_q)
      R_IDLE:  if (ar_hs) rst_nxt = R_RESP;
      R_RESP:  if (r_hs)  rst_nxt = R_IDLE;
      default: rst_nxt = R_IDLE;
    endcase
  end

  // Sampled at AR handshake, so a same-cycle write commit is not visible
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_val;
      rresp_q <= rd_resp;
    end
  end

  assign i2c_en       = ctrl_q[CTRL_EN];
  assign i2c_start    = start_q;
  assign i2c_tx_data  = txd_q[7:0];
  assign i2c_slv_addr = saddr_q[6:0];
  assign i2c_rw       = saddr_q[8];

  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

endmodule

// File: tb/tb_i2c_m_axil_slave.sv
// Directed + randomized bench for i2c_m_axil_slave against a register-map model.
module tb_i2c_m_axil_slave;

`ifdef I2C_M_AXIL_SLVERR_EN
  localparam logic [1:0] BAD_RESP = 2'b10;
`else
  localparam logic [1:0] BAD_RESP = 2'b00;
`endif

  logic       ACLK = 1'b0;
  logic       ARESETN = 1'b0;
  logic       i2c_en, i2c_start, i2c_rw;
  logic [7:0] i2c_tx_data;
  logic [6:0] i2c_slv_addr;
  logic       i2c_busy, i2c_done, i2c_ack_err;
  logic [7:0] i2c_rx_data;

  always #5 ACLK = ~ACLK;

  i2c_m_axil_slave_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  i2c_m_axil_slave dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(bus),
    .i2c_en(i2c_en), .i2c_start(i2c_start), .i2c_tx_data(i2c_tx_data),
    .i2c_slv_addr(i2c_slv_addr), .i2c_rw(i2c_rw), .i2c_busy(i2c_busy),
    .i2c_done(i2c_done), .i2c_ack_err(i2c_ack_err), .i2c_rx_data(i2c_rx_data)
  );

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  // Reference model: four RW words plus the two sticky status flags
  logic [31:0] m [4];
  logic        m_done, m_ack;

  always @(negedge ACLK) if (i2c_start === 1'b1) start_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 4; i++) m[i] = '0;
    m_done = 1'b0;
    m_ack  = 1'b0;
  endtask

  task automatic mdl_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int idx;
    idx = int'(a[4:2]);
    resp = 2'b00;
    if (idx < 4) begin
      for (int b = 0; b < 4; b++) if (s[b]) m[idx][8*b +: 8] = d[8*b +: 8];
      if (idx == 0) begin
        m[0][1] = 1'b0;
        m[0][2] = 1'b0;
        if (s[0] && d[2]) begin m_done = 1'b0; m_ack = 1'b0; end
      end
    end else resp = BAD_RESP;
  endtask

  task automatic mdl_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    int idx;
    idx = int'(a[4:2]);
    resp = 2'b00;
    d = '0;
    if (idx < 4)       d = m[idx];
    else if (idx == 4) d = {29'b0, m_ack, m_done, i2c_busy};
    else if (idx == 5) d = {24'b0, i2c_rx_data};
    else               resp = BAD_RESP;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly,
                           output logic [1:0] resp, output logic st);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 32) begin
      bus.awvalid = !aw_done && (n >= aw_dly);
      bus.wvalid  = !w_done  && (n >= w_dly);
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid  && bus.wready;
      @(posedge ACLK); #1;
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      n++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    chk("wr_addr_data_accept", 32'(aw_done && w_done), 32'd1);
    n = 0;
    while (!bus.bvalid && n < 32) begin @(posedge ACLK); #1; n++; end
    chk("wr_bvalid_timeout", 32'(bus.bvalid), 32'd1);
    st = i2c_start;
    resp = bus.bresp;
    bus.bready = 1'b1;
    @(posedge ACLK); #1;
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, input int dly,
                          output logic [31:0] d, output logic [1:0] resp);
    bit done, hs;
    int n;
    bus.araddr = a; done = 0; n = 0;
    while (!done && n < 32) begin
      bus.arvalid = (n >= dly);
      hs = bus.arvalid && bus.arready;
      @(posedge ACLK); #1;
      if (hs) done = 1;
      n++;
    end
    bus.arvalid = 1'b0;
    chk("rd_addr_accept", 32'(done), 32'd1);
    n = 0;
    while (!bus.rvalid && n < 32) begin @(posedge ACLK); #1; n++; end
    chk("rd_rvalid_timeout", 32'(bus.rvalid), 32'd1);
    d = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    @(posedge ACLK); #1;
    bus.rready = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [4:0] a, input logic [31:0] d,
                    input logic [3:0] s, input int awd, input int wd);
    logic [1:0] resp, er;
    logic st;
    axi_write(a, d, s, awd, wd, resp, st);
    mdl_write(a, d, s, er);
    chk(tag, 32'(resp), 32'(er));
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input int dly);
    logic [31:0] d, ed;
    logic [1:0]  resp, er;
    mdl_read(a, ed, er);
    axi_read(a, dly, d, resp);
    chk({tag, "_resp"}, 32'(resp), 32'(er));
    if (er == 2'b00) chk({tag, "_data"}, d, ed);
  endtask

  initial begin
    logic [1:0]  resp, er;
    logic        st;
    logic [31:0] d, old, nd;
    int          sc;

    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    i2c_busy = 1'b0; i2c_done = 1'b0; i2c_ack_err = 1'b0; i2c_rx_data = 8'h00;
    mdl_reset();

    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_awready", 32'(bus.awready), 32'd1);
    chk("rst_wready",  32'(bus.wready),  32'd1);
    chk("rst_arready", 32'(bus.arready), 32'd1);
    chk("rst_bvalid",  32'(bus.bvalid),  32'd0);
    chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
    chk("rst_bresp",   32'(bus.bresp),   32'd0);
    chk("rst_rresp",   32'(bus.rresp),   32'd0);
    chk("rst_start",   32'(i2c_start),   32'd0);
    chk("rst_en",      32'(i2c_en),      32'd0);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;

    // basic write then read-back of every RW word
    for (int i = 0; i < 4; i++) wr("wr_basic", 5'(i * 4), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) rd("rd_basic", 5'(i * 4), 0);

    // W three cycles ahead of AW, response back-pressured for four cycles
    bus.wdata = 32'hA5A5_0F0F; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge ACLK); #1;
    bus.wvalid = 1'b0;
    repeat (2) begin
      chk("early_w_wready_low", 32'(bus.wready), 32'd0);
      chk("early_w_awready_hi", 32'(bus.awready), 32'd1);
      chk("early_w_no_bvalid", 32'(bus.bvalid), 32'd0);
      @(posedge ACLK); #1;
    end
    bus.awaddr = 5'h0C; bus.awvalid = 1'b1;
    @(posedge ACLK); #1;
    bus.awvalid = 1'b0;
    repeat (4) begin
      chk("bp_bvalid_held", 32'(bus.bvalid), 32'd1);
      chk("bp_bresp_stable", 32'(bus.bresp), 32'd0);
      chk("bp_awready_low", 32'(bus.awready), 32'd0);
      @(posedge ACLK); #1;
    end
    bus.bready = 1'b1;
    @(posedge ACLK); #1;
    bus.bready = 1'b0;
    chk("bp_ready_back", 32'({bus.awready, bus.wready}), 32'd3);
    chk("bp_bvalid_drop", 32'(bus.bvalid), 32'd0);
    mdl_write(5'h0C, 32'hA5A5_0F0F, 4'hF, er);
    rd("rd_early_w", 5'h0C, 0);

    // START pulse and enable
    sc = start_cnt;
    axi_write(5'h00, 32'h3, 4'hF, 0, 0, resp, st);
    mdl_write(5'h00, 32'h3, 4'hF, er);
    chk("start_with_bvalid", 32'(st), 32'd1);
    chk("start_one_cycle", 32'(start_cnt - sc), 32'd1);
    chk("en_set", 32'(i2c_en), 32'd1);
    rd("rd_ctrl_start", 5'h00, 0);
    sc = start_cnt;
    axi_write(5'h00, 32'h3, 4'b0010, 1, 0, resp, st);
    mdl_write(5'h00, 32'h3, 4'b0010, er);
    chk("no_start_strb", 32'(start_cnt - sc), 32'd0);
    chk("en_kept", 32'(i2c_en), 32'd1);

    // sticky status
    i2c_done = 1'b1; i2c_ack_err = 1'b1;
    @(posedge ACLK); #1;
    i2c_done = 1'b0; i2c_ack_err = 1'b0;
    m_done = 1'b1; m_ack = 1'b1;
    rd("rd_status_sticky", 5'h10, 0);
    i2c_busy = 1'b1;
    rd("rd_status_busy", 5'h10, 0);
    i2c_busy = 1'b0;

    // clear racing a new done pulse in the commit cycle: done survives
    bus.awaddr = 5'h00; bus.wdata = 32'h5; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; i2c_done = 1'b1;
    @(posedge ACLK); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; i2c_done = 1'b0;
    chk("clr_race_bvalid", 32'(bus.bvalid), 32'd1);
    bus.bready = 1'b1;
    @(posedge ACLK); #1;
    bus.bready = 1'b0;
    mdl_write(5'h00, 32'h5, 4'hF, er);
    m_done = 1'b1;
    rd("rd_status_race", 5'h10, 0);
    wr("wr_clear", 5'h00, 32'h4, 4'hF, 0, 2);
    rd("rd_status_clr", 5'h10, 0);

    // RO / unmapped offsets
    i2c_rx_data = 8'h3C;
    wr("wr_status_ro", 5'h10, 32'hFFFF_FFFF, 4'hF, 0, 0);
    wr("wr_rxd_ro", 5'h14, 32'hFFFF_FFFF, 4'hF, 0, 0);
    wr("wr_unmapped", 5'h1C, 32'hFFFF_FFFF, 4'hF, 0, 0);
    rd("rd_status_after_ro", 5'h10, 0);
    rd("rd_rxd", 5'h14, 0);
    rd("rd_unmapped", 5'h18, 0);
    axi_read(5'h1C, 0, d, resp);
    chk("rd_unmapped_1c_resp", 32'(resp), 32'(BAD_RESP));
    if (BAD_RESP == 2'b00) chk("rd_unmapped_1c_zero", d, 32'h0);
    for (int i = 0; i < 4; i++) rd("rd_after_ro", 5'(i * 4), 0);

    // write commit and read of the same word in one cycle: read sees old value
    old = m[3];
    nd  = 32'h1234_5678;
    bus.awaddr = 5'h0C; bus.wdata = nd; bus.wstrb = 4'hF; bus.araddr = 5'h0C;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    @(posedge ACLK); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    chk("same_cyc_bvalid", 32'(bus.bvalid), 32'd1);
    chk("same_cyc_rvalid", 32'(bus.rvalid), 32'd1);
    chk("same_cyc_old_data", bus.rdata, old);
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(posedge ACLK); #1;
    bus.bready = 1'b0; bus.rready = 1'b0;
    mdl_write(5'h0C, nd, 4'hF, er);
    rd("rd_same_cyc_new", 5'h0C, 0);

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      i2c_busy    = 1'($urandom);
      i2c_rx_data = 8'($urandom);
      if ($urandom_range(0, 1) == 0)
        wr("rnd_wr", 5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 3), $urandom_range(0, 3));
      else
        rd("rnd_rd", 5'($urandom_range(0, 31)), $urandom_range(0, 2));
    end
    chk("out_en", 32'(i2c_en), 32'(m[0][0]));
    chk("out_tx_data", 32'(i2c_tx_data), 32'(m[1][7:0]));
    chk("out_slv_addr", 32'(i2c_slv_addr), 32'(m[2][6:0]));
    chk("out_rw", 32'(i2c_rw), 32'(m[2][8]));

    // reset while a read response is outstanding
    i2c_busy = 1'b0;
    wr("wr_pre_rst_ctrl", 5'h00, 32'h1, 4'hF, 0, 0);
    wr("wr_pre_rst_txd", 5'h04, 32'hDEAD_BEEF, 4'hF, 0, 0);
    bus.araddr = 5'h04; bus.arvalid = 1'b1;
    @(posedge ACLK); #1;
    bus.arvalid = 1'b0;
    @(posedge ACLK); #1;
    chk("pre_rst_rvalid", 32'(bus.rvalid), 32'd1);
    #2 ARESETN = 1'b0;
    #1;
    chk("rst_async_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_async_en", 32'(i2c_en), 32'd0);
    chk("rst_async_tx", 32'(i2c_tx_data), 32'd0);
    mdl_reset();
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    @(posedge ACLK); #1;
    chk("post_rst_readys", 32'({bus.awready, bus.wready, bus.arready}), 32'd7);
    for (int i = 0; i < 5; i++) rd("rd_post_rst", 5'(i * 4), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
